// File: rtl/sr_bank_pkg.sv
// rtl/sr_bank_pkg.sv - opcodes and FSM state encoding for sr_bank_arbiter
package sr_bank_pkg;

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_SET = 2'd1;
  localparam logic [1:0] OP_CLR = 2'd2;
  localparam logic [1:0] OP_TGL = 2'd3;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_ISSUE_ENC  = 2'd1;
  localparam logic [1:0] ST_SETTLE_ENC = 2'd2;
  localparam logic [1:0] ST_DONE_ENC   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_ISSUE  = ST_ISSUE_ENC,
    ST_SETTLE = ST_SETTLE_ENC,
    ST_DONE   = ST_DONE_ENC
  } state_t;

endpackage

// File: rtl/sr_bank_arbiter_rr.sv
// rtl/sr_bank_arbiter_rr.sv - combinational round-robin winner select
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [PW-1:0]   win_idx
);

  // scan upward from ptr with wrap-around; the first requester found wins
  always_comb begin
    int   jj;
    logic found;
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    jj      = 0;
    for (int k = 0; k < NREQ; k++) begin
      jj = int'(ptr) + k;
      if (jj >= NREQ) jj = jj - NREQ;
      if (!found && req[PW'(jj)]) begin
        found              = 1'b1;
        win_oh[PW'(jj)]    = 1'b1;
        win_idx            = PW'(jj);
      end
    end
  end

endmodule

// File: rtl/sr_bank_arbiter.sv
// rtl/sr_bank_arbiter.sv - round-robin sequencer sharing one sr flip-flop bank
module sr_bank_arbiter
  import sr_bank_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDXW = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [IDXW*NREQ-1:0] idx,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic                 rdata,
  output logic                 err,
  output logic                 busy,
  output logic [W-1:0]         s_vec,
  output logic [W-1:0]         r_vec,
  input  logic [W-1:0]         q_vec
);

  localparam int PW = $clog2(NREQ);

  state_t          state, state_n;
  logic [PW-1:0]   ptr, ptr_n, win_idx;
  logic [NREQ-1:0] win_oh, gnt_n, ack_n;
  logic [IDXW-1:0] idx_q, idx_n, sel_idx;
  logic [1:0]      sel_op;
  logic            err_q, err_q_n, rdata_n, err_n, busy_n;
  logic            sel_oor, q_bit;
  logic [W-1:0]    sel_oh, idx_q_oh, s_n, r_n;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req    (req),
    .ptr    (ptr),
    .win_oh (win_oh),
    .win_idx(win_idx)
  );

  // pick the winner's opcode and bit index out of the packed request buses
  always_comb begin
    sel_idx = '0;
    sel_op  = OP_NOP;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh[i]) begin
        sel_idx = idx[IDXW*i +: IDXW];
        sel_op  = op[2*i +: 2];
      end
    end
  end

  assign sel_oor  = (int'(sel_idx) >= W);
  assign sel_oh   = W'(1) << sel_idx;
  assign q_bit    = |(q_vec & sel_oh);
  assign idx_q_oh = W'(1) << idx_q;

  // next-state and next-output logic; s_n/r_n only ever carry one one-hot side
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idx_n   = idx_q;
    err_q_n = err_q;
    gnt_n   = gnt;
    ack_n   = ack;
    rdata_n = rdata;
    err_n   = err;
    busy_n  = busy;
    s_n     = s_vec;
    r_n     = r_vec;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          gnt_n   = win_oh;
          busy_n  = 1'b1;
          idx_n   = sel_idx;
          err_q_n = sel_oor;
          s_n     = '0;
          r_n     = '0;
          if (!sel_oor) begin
            case (sel_op)
              OP_SET:  s_n = sel_oh;
              OP_CLR:  r_n = sel_oh;
              OP_TGL:  if (q_bit) r_n = sel_oh; else s_n = sel_oh;
              default: ;
            endcase
          end
          ptr_n   = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        s_n     = '0;
        r_n     = '0;
        state_n = ST_SETTLE;
      end
      ST_SETTLE: begin
        rdata_n = err_q ? 1'b0 : |(q_vec & idx_q_oh);
        err_n   = err_q;
        ack_n   = gnt;
        state_n = ST_DONE;
      end
      ST_DONE: begin
        ack_n   = '0;
        gnt_n   = '0;
        err_n   = 1'b0;
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // state and output registers; reset leaves the bank itself alone
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr   <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
      gnt   <= '0;
      ack   <= '0;
      rdata <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
      s_vec <= '0;
      r_vec <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      idx_q <= idx_n;
      err_q <= err_q_n;
      gnt   <= gnt_n;
      ack   <= ack_n;
      rdata <= rdata_n;
      err   <= err_n;
      busy  <= busy_n;
      s_vec <= s_n;
      r_vec <= r_n;
    end
  end

  a_no_sr:     assert property (@(posedge clk) disable iff (rst) (s_vec & r_vec) == '0);
  a_one_drive: assert property (@(posedge clk) disable iff (rst) $onehot0(s_vec | r_vec));
  a_gnt_oh:    assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_ack_gnt:   assert property (@(posedge clk) disable iff (rst) (ack & ~gnt) == '0);

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// tb/tb_sr_bank_arbiter.sv - randomized self-checking bench for sr_bank_arbiter
module tb_sr_bank_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 6;
  localparam int IDXW = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [2*NREQ-1:0]    op;
  logic [IDXW*NREQ-1:0] idx;
  logic [NREQ-1:0]      gnt, ack;
  logic                 rdata, err, busy;
  logic [W-1:0]         s_vec, r_vec;
  logic [W-1:0]         q_vec = '0;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] mdl_bank = '0;
  int           mdl_ptr  = 0;

  sr_bank_arbiter #(.NREQ(NREQ), .W(W), .IDXW(IDXW)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .op   (op),
    .idx  (idx),
    .gnt  (gnt),
    .ack  (ack),
    .rdata(rdata),
    .err  (err),
    .busy (busy),
    .s_vec(s_vec),
    .r_vec(r_vec),
    .q_vec(q_vec)
  );

  always #5 clk = ~clk;

  // the shared bank: set wins where s=1, clear where r=1
  always @(posedge clk)
    if (!$isunknown({s_vec, r_vec})) q_vec <= (q_vec | s_vec) & ~r_vec;

  // one complete transaction, entered and left at a negedge with the DUT idle
  task automatic do_txn(input logic [NREQ-1:0] rq, input logic [2*NREQ-1:0] opv,
                        input logic [IDXW*NREQ-1:0] idxv, input bit hold);
    int w, i;
    logic [1:0] o;
    bit oor;
    logic old, nb, erd;
    logic [W-1:0] es, er;
    logic [NREQ-1:0] eg;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (mdl_ptr + k) % NREQ;
      if (w < 0 && rq[j]) w = j;
    end
    o   = opv[2*w +: 2];
    i   = int'(idxv[IDXW*w +: IDXW]);
    oor = (i >= W);
    old = oor ? 1'b0 : mdl_bank[i];
    case (o)
      2'd1:    nb = 1'b1;
      2'd2:    nb = 1'b0;
      2'd3:    nb = ~old;
      default: nb = old;
    endcase
    es = '0;
    er = '0;
    if (!oor) begin
      if (nb && !old) es[i] = 1'b1;
      if (!nb && old) er[i] = 1'b1;
      if (o == 2'd1 && old) es[i] = 1'b1;
      if (o == 2'd2 && !old) er[i] = 1'b1;
      mdl_bank[i] = nb;
    end
    erd = oor ? 1'b0 : nb;
    eg = '0;
    eg[w] = 1'b1;
    mdl_ptr = (w + 1) % NREQ;

    req = rq; op = opv; idx = idxv;
    @(negedge clk);
    total++; if (gnt !== eg) begin bad++; $display("FAIL grant: got %b want %b", gnt, eg); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_on: got %b want 1", busy); end
    total++; if (s_vec !== es) begin bad++; $display("FAIL s_drive: got %h want %h", s_vec, es); end
    total++; if (r_vec !== er) begin bad++; $display("FAIL r_drive: got %h want %h", r_vec, er); end
    @(negedge clk);
    total++; if ((s_vec | r_vec) !== '0) begin bad++; $display("FAIL drive_clear: got s=%h r=%h want 0", s_vec, r_vec); end
    total++; if (q_vec !== mdl_bank) begin bad++; $display("FAIL bank: got %h want %h", q_vec, mdl_bank); end
    @(negedge clk);
    total++; if (ack !== eg) begin bad++; $display("FAIL ack: got %b want %b", ack, eg); end
    total++; if (rdata !== erd) begin bad++; $display("FAIL rdata: got %b want %b (req %0d idx %0d op %0d)", rdata, erd, w, i, o); end
    total++; if (err !== oor) begin bad++; $display("FAIL err: got %b want %b", err, oor); end
    if (!hold) req = '0;
    @(negedge clk);
    total++; if ({ack, gnt, busy, err} !== '0) begin bad++; $display("FAIL done_clear: got ack=%b gnt=%b busy=%b err=%b want 0", ack, gnt, busy, err); end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; op = '0; idx = '0;
    repeat (2) @(negedge clk);
    total++; if (gnt !== '0) begin bad++; $display("FAIL rst_gnt: got %b want 0", gnt); end
    total++; if (ack !== '0) begin bad++; $display("FAIL rst_ack: got %b want 0", ack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if ({s_vec, r_vec} !== '0) begin bad++; $display("FAIL rst_drive: got s=%h r=%h want 0", s_vec, r_vec); end
    total++; if ({rdata, err} !== 2'b00) begin bad++; $display("FAIL rst_rdata_err: got %b%b want 00", rdata, err); end
    rst = 1'b0;
    mdl_ptr = 0;
  endtask

  task automatic test_single_set();
    do_txn(4'b0001, 8'b00_00_00_01, 12'd5, 1'b0);
    total++; if (q_vec[5] !== 1'b1) begin bad++; $display("FAIL set_bit5: got %b want 1", q_vec[5]); end
  endtask

  task automatic test_toggle_twice();
    total++; if (q_vec[2] !== 1'b0) begin bad++; $display("FAIL tgl_init: got %b want 0", q_vec[2]); end
    do_txn(4'b0010, 8'b00_00_11_00, 12'(2 << IDXW), 1'b0);
    do_txn(4'b0010, 8'b00_00_11_00, 12'(2 << IDXW), 1'b0);
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl_ptr = 0;
    for (int n = 0; n < 5; n++) do_txn(4'b1111, 8'h00, 12'h000, (n != 4));
  endtask

  task automatic test_out_of_range();
    do_txn(4'b0100, 8'b00_01_00_00, 12'(7 << (2*IDXW)), 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] exp_s;
    exp_s = W'(1) << 3;
    mdl_bank[3] = 1'b1;
    req = 4'b0010; op = 8'b00_00_01_00; idx = 12'(3 << IDXW);
    @(negedge clk);
    total++; if (s_vec !== exp_s) begin bad++; $display("FAIL mid_issue: got %h want %h", s_vec, exp_s); end
    rst = 1'b1; req = '0;
    @(negedge clk);
    total++; if ({s_vec, r_vec} !== '0) begin bad++; $display("FAIL mid_drive: got s=%h r=%h want 0", s_vec, r_vec); end
    total++; if ({gnt, busy, ack} !== '0) begin bad++; $display("FAIL mid_ctrl: got gnt=%b busy=%b ack=%b want 0", gnt, busy, ack); end
    total++; if (q_vec !== mdl_bank) begin bad++; $display("FAIL mid_bank: got %h want %h", q_vec, mdl_bank); end
    rst = 1'b0;
    mdl_ptr = 0;
    @(negedge clk);
    total++; if (ack !== '0) begin bad++; $display("FAIL mid_noack: got %b want 0", ack); end
    do_txn(4'b0111, 8'($urandom), 12'($urandom), 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 2500; n++)
      do_txn(4'($urandom_range(1, 15)), 8'($urandom), 12'($urandom), 1'($urandom));
    req = '0;
    @(negedge clk);
    total++; if (q_vec !== mdl_bank) begin bad++; $display("FAIL rand_bank: got %h want %h", q_vec, mdl_bank); end
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_toggle_twice();
    test_round_robin();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
